// File: rtl/retire_unit.sv
// In-order commit end of the ROB. Dispatch enqueues at the tail, completions
// mark entries done, and up to two done entries retire from the head per cycle.
// Ports:
//   clk, reset (async, active-high)
//   enq_*          : dispatch enqueue, returns enq_rob_index (= tail), full/empty
//   cmp_k_*        : four completion ports (FU1, FU2, FU3, LSQ), highest k wins
//   freed_tag_*    : old physical tags released to the rename free list
//   a0, a1         : committed x10 / x11
//   retired_count  : total retired instructions, wraps at 2^32
//   overflow_err   : sticky, enqueue attempted while full
module retire_unit #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  input  logic [4:0]       enq_arch_rd,
  input  logic             enq_writes_rd,
  input  logic [TAG_W-1:0] enq_old_tag,
  output logic [IDX_W-1:0] enq_rob_index,
  output logic             full,
  output logic             empty,
  input  logic             cmp_0_valid,
  input  logic [IDX_W-1:0] cmp_0_rob_index,
  input  logic [31:0]      cmp_0_value,
  input  logic             cmp_1_valid,
  input  logic [IDX_W-1:0] cmp_1_rob_index,
  input  logic [31:0]      cmp_1_value,
  input  logic             cmp_2_valid,
  input  logic [IDX_W-1:0] cmp_2_rob_index,
  input  logic [31:0]      cmp_2_value,
  input  logic             cmp_3_valid,
  input  logic [IDX_W-1:0] cmp_3_rob_index,
  input  logic [31:0]      cmp_3_value,
  output logic             freed_tag_1_valid,
  output logic [TAG_W-1:0] freed_tag_1,
  output logic             freed_tag_2_valid,
  output logic [TAG_W-1:0] freed_tag_2,
  output logic [31:0]      a0,
  output logic [31:0]      a1,
  output logic [31:0]      retired_count,
  output logic             overflow_err
);

  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_wr;
  logic [31:0]      r_val [DEPTH];
  logic [4:0]       r_rd  [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];

  logic             r_f1v;
  logic [TAG_W-1:0] r_f1;
  logic             r_f2v;
  logic [TAG_W-1:0] r_f2;
  logic [31:0]      r_a0;
  logic [31:0]      r_a1;
  logic [31:0]      r_ret_cnt;
  logic             r_ovf;

  logic             w_cv   [4];
  logic [IDX_W-1:0] w_ci   [4];
  logic [31:0]      w_cval [4];
  logic [IDX_W-1:0] w_off  [4];
  logic [3:0]       w_ok;

  logic [IDX_W-1:0] w_h1;
  logic             w_r1;
  logic             w_r2;
  logic [1:0]       w_nret;
  logic             w_enq;
  logic             w_f1v;
  logic             w_f2v;

  assign w_cv[0]   = cmp_0_valid;
  assign w_cv[1]   = cmp_1_valid;
  assign w_cv[2]   = cmp_2_valid;
  assign w_cv[3]   = cmp_3_valid;
  assign w_ci[0]   = cmp_0_rob_index;
  assign w_ci[1]   = cmp_1_rob_index;
  assign w_ci[2]   = cmp_2_rob_index;
  assign w_ci[3]   = cmp_3_rob_index;
  assign w_cval[0] = cmp_0_value;
  assign w_cval[1] = cmp_1_value;
  assign w_cval[2] = cmp_2_value;
  assign w_cval[3] = cmp_3_value;

  assign full          = (r_count == CNT_W'(DEPTH));
  assign empty         = (r_count == '0);
  assign enq_rob_index = r_tail;
  assign w_enq         = enq_valid && !full;

  assign w_h1   = r_head + IDX_W'(1);
  assign w_r1   = (r_count != '0) && r_done[r_head];
  assign w_r2   = w_r1 && (r_count >= CNT_W'(2)) && r_done[w_h1];
  assign w_nret = {1'b0, w_r1} + {1'b0, w_r2};

  assign w_f1v = w_r1 && r_wr[r_head] && (r_tag[r_head] != '0);
  assign w_f2v = w_r2 && r_wr[w_h1] && (r_tag[w_h1] != '0);

  // Offset from head decides whether an index is allocated; entries
  // retiring this cycle are already done, so late completions drop.
  genvar k;
  for (k = 0; k < 4; k++) begin : g_cmp
    assign w_off[k] = w_ci[k] - r_head;
    assign w_ok[k]  = w_cv[k]
                   && ({1'b0, w_off[k]} < r_count)
                   && !(w_r1 && (w_ci[k] == r_head))
                   && !(w_r2 && (w_ci[k] == w_h1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_done  <= '0;
    end else begin
      if (w_r1) r_done[r_head] <= 1'b0;
      if (w_r2) r_done[w_h1]   <= 1'b0;
      if (w_enq) begin
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + IDX_W'(1);
      end
      // Later ports override earlier ones on the same index.
      for (int i = 0; i < 4; i++) begin
        if (w_ok[i]) r_done[w_ci[i]] <= 1'b1;
      end
      r_head  <= r_head + IDX_W'(w_nret);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_nret);
    end
  end

  // Payload storage needs no reset; done bits gate every use.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_tail]  <= enq_arch_rd;
      r_wr[r_tail]  <= enq_writes_rd;
      r_tag[r_tail] <= enq_old_tag;
    end
    for (int i = 0; i < 4; i++) begin
      if (w_ok[i]) r_val[w_ci[i]] <= w_cval[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f1v     <= 1'b0;
      r_f1      <= '0;
      r_f2v     <= 1'b0;
      r_f2      <= '0;
      r_a0      <= '0;
      r_a1      <= '0;
      r_ret_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_f1v     <= w_f1v;
      r_f1      <= w_f1v ? r_tag[r_head] : '0;
      r_f2v     <= w_f2v;
      r_f2      <= w_f2v ? r_tag[w_h1] : '0;
      r_ret_cnt <= r_ret_cnt + 32'(w_nret);
      if (enq_valid && full) r_ovf <= 1'b1;
      // The younger retiree is checked first so it wins on a shared rd.
      if (w_r2 && r_wr[w_h1] && (r_rd[w_h1] == 5'd10))
        r_a0 <= r_val[w_h1];
      else if (w_r1 && r_wr[r_head] && (r_rd[r_head] == 5'd10))
        r_a0 <= r_val[r_head];
      if (w_r2 && r_wr[w_h1] && (r_rd[w_h1] == 5'd11))
        r_a1 <= r_val[w_h1];
      else if (w_r1 && r_wr[r_head] && (r_rd[r_head] == 5'd11))
        r_a1 <= r_val[r_head];
    end
  end

  assign freed_tag_1_valid = r_f1v;
  assign freed_tag_1       = r_f1;
  assign freed_tag_2_valid = r_f2v;
  assign freed_tag_2       = r_f2;
  assign a0                = r_a0;
  assign a1                = r_a1;
  assign retired_count     = r_ret_cnt;
  assign overflow_err      = r_ovf;

endmodule
